systolic_result_collector: RTL and testbench
============================================

Name: systolic_result_collector

Overview:
- Receiver at the far end of the systolic array's result shift chains.
- Each PE row drains its accumulators as a valid-only stream (data + valid, no backpressure). This block captures one stream per row into a per-row FIFO.
- It re-emits the tile as one row-major valid/ready stream, with a last flag on the final beat, to the host-side DMA/writeback logic.
- It flags any beat lost to FIFO overflow.

Parameters:
- D_W_ACC, 64, accumulator/result data width
- N_ROWS, 4, number of PE rows (result chains)
- N_COLS, 4, results per row per tile (PEs per row)
- FIFO_DEPTH, 8, entries per row FIFO; power of 2, >= N_COLS

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  N_ROWS*D_W_ACC  chain outputs; row r at bits [r*D_W_ACC +: D_W_ACC]
- in_valid  in  N_ROWS  per-row beat valid
- m_data  out  D_W_ACC  output result
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_last  out  1  final beat of tile (row N_ROWS-1, col N_COLS-1)
- m_row  out  $clog2(N_ROWS)  row index of current beat
- overflow  out  1  sticky: a beat was dropped
- clr_overflow  in  1  clears overflow
- tile_done  out  1  one-cycle pulse after last beat handshakes

Behaviour:
- Reset values: all FIFOs empty; state IDLE; row/col counters 0; overflow 0; tile_done 0.
- Reset outputs: m_valid 0, m_last 0, m_row 0.
- Reset mid-tile discards all buffered beats. No partial beat is emitted afterwards.
- Ingress, per row r, every cycle:
  - in_valid[r]=1 and FIFO r not full: write in_data row r.
  - FIFO r full and not popped this cycle: beat dropped, overflow set.
  - FIFO r full and popped this cycle: write accepted (simultaneous push/pop on full is legal).
  - Rows are written independently and concurrently.
- Overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow=1 clears it next cycle.
- FIFOs are first-word fall-through. A beat written at edge t is visible on m_data after edge t, so minimum ingress-to-m_valid latency is 1 cycle.
- Egress state machine:
  - IDLE: cur_row=0, cur_col=0, m_valid=0. Go to DRAIN when FIFO 0 is non-empty.
  - DRAIN:
    - m_valid = !empty(FIFO cur_row); m_data = head of FIFO cur_row; m_row = cur_row.
    - m_last = (cur_row==N_ROWS-1 && cur_col==N_COLS-1) && m_valid.
    - On handshake (m_valid & m_ready): pop the FIFO, cur_col++.
    - At cur_col==N_COLS-1: cur_col=0, cur_row++.
    - Handshake on the m_last beat: go to DONE.
  - DONE: tile_done=1 for exactly one cycle, then IDLE.
    - FIFOs keep accepting beats; the next tile's beats simply wait.
- Ordering:
  - Output is strictly row-major regardless of arrival order.
  - Rows that arrive early wait in their FIFO. A stall on an empty cur_row FIFO holds m_valid=0 without advancing.
- Stability: once m_valid=1, m_data/m_row/m_last hold until handshake. The head changes only on pop; counters change only on handshake.
- Arithmetic: counters wrap exactly at N_COLS-1 / N_ROWS-1. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with the wrap bit used for full/empty.
- m_ready may be asserted with m_valid=0; this has no effect.

Decomposition:
- Package systolic_pkg:
  - Shared constants D_W_ACC, N_ROWS, N_COLS.
  - Derived ROW_W=$clog2(N_ROWS), COL_W=$clog2(N_COLS).
  - Collector state encoding (IDLE, DRAIN, DONE).
- Sub-module result_fifo:
  - Synchronous FWFT FIFO with params D_W, DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
  - Supports push-while-full-with-pop.
  - Instantiated N_ROWS times by generate.

Test Plan:
1. Basic tile order. Stimulus: m_ready=1; rows 0..3 each push 4 beats with value 16*r+c, rows staggered 2 cycles apart. Required: m_data = 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33; m_row matches; m_last only on 0x33; tile_done pulses 1 cycle later.
2. Out-of-order arrival. Stimulus: row 3 pushes its 4 beats first, then rows 2, 1, 0. Required: no output until row 0 data lands. Output order is still row-major, 16 beats, then tile_done.
3. Backpressure. Stimulus: m_ready toggles 1,0,0,1 during drain. Required: m_data/m_row/m_last stable while m_valid=1 and m_ready=0; no beat lost or duplicated; 16 beats total.
4. Overflow. Stimulus: m_ready=0; row 1 pushes 9 beats with FIFO_DEPTH=8. Required: 9th beat dropped and overflow=1 the next cycle. clr_overflow clears it. After releasing m_ready, the first 8 beats of row 1 are intact.
5. Full with simultaneous push/pop. Stimulus: row 0 FIFO full and head handshaking while in_valid[0]=1. Required: new beat accepted; overflow stays 0; count stays 8.
6. Reset mid-drain. Stimulus: rst=1 for 1 cycle after 5 beats of a tile have been emitted. Required: m_valid=0, overflow=0, FIFOs empty. A fresh full tile then drains correctly from row 0, col 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state encoding for the systolic result collector
package systolic_pkg;

    localparam int D_W_ACC = 64;
    localparam int N_ROWS  = 4;
    localparam int N_COLS  = 4;
    localparam int ROW_W   = $clog2(N_ROWS);
    localparam int COL_W   = $clog2(N_COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } collector_state_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word fall-through FIFO holding one PE row's drained results
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request and data; accepted when not full, or when full and popped
//   pop               remove the head entry (ignored when empty)
//   head              current head entry, valid whenever empty is low
//   empty, full       occupancy flags
module result_fifo #(
    parameter int D_W   = 64,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [D_W-1:0] push_data,
    input  logic           pop,
    output logic [D_W-1:0] head,
    output logic           empty,
    output logic           full
);

    localparam int AW = $clog2(DEPTH);

    logic [D_W-1:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_pop;
    logic           do_push;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - captures per-row result chains and re-emits the tile row-major
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_data        per-row chain outputs, row r at [r*D_W_ACC +: D_W_ACC]
//   in_valid       per-row beat valid (no backpressure on ingress)
//   m_data         output result beat
//   m_valid        output beat valid
//   m_ready        downstream accept
//   m_last         final beat of the tile (last row, last column)
//   m_row          row index of the current beat
//   overflow       sticky flag: an ingress beat was dropped on a full FIFO
//   clr_overflow   clears overflow (a same-cycle drop wins)
//   tile_done      one-cycle pulse after the last beat handshakes
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ROWS*D_W_ACC-1:0] in_data,
    input  logic [N_ROWS-1:0]         in_valid,
    output logic [D_W_ACC-1:0]        m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [ROW_W-1:0]          m_row,
    output logic                      overflow,
    input  logic                      clr_overflow,
    output logic                      tile_done
);

    logic [N_ROWS-1:0]  fifo_empty;
    logic [N_ROWS-1:0]  fifo_full;
    logic [N_ROWS-1:0]  fifo_pop;
    logic [D_W_ACC-1:0] fifo_head [N_ROWS];
    logic [N_ROWS-1:0]  drop;

    collector_state_t   state, state_nxt;
    logic [ROW_W-1:0]   cur_row, row_nxt;
    logic [COL_W-1:0]   cur_col, col_nxt;
    logic               at_last_row;
    logic               at_last_col;

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        result_fifo #(
            .D_W   (D_W_ACC),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[r]),
            .push_data (in_data[r*D_W_ACC +: D_W_ACC]),
            .pop       (fifo_pop[r]),
            .head      (fifo_head[r]),
            .empty     (fifo_empty[r]),
            .full      (fifo_full[r])
        );
    end

    assign drop = in_valid & fifo_full & ~fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            state   <= state_nxt;
            cur_row <= row_nxt;
            cur_col <= col_nxt;
        end
    end

    assign at_last_row = (cur_row == ROW_W'(N_ROWS - 1));
    assign at_last_col = (cur_col == COL_W'(N_COLS - 1));

    // m_data/m_row follow the head of cur_row; the head only moves on a pop,
    // so they stay stable while a beat is stalled.
    assign m_data = fifo_head[cur_row];
    assign m_row  = cur_row;

    always_comb begin
        state_nxt = state;
        row_nxt   = cur_row;
        col_nxt   = cur_col;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        tile_done = 1'b0;
        fifo_pop  = '0;
        case (state)
            ST_IDLE: begin
                row_nxt = '0;
                col_nxt = '0;
                if (!fifo_empty[0]) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                m_valid = !fifo_empty[cur_row];
                m_last  = at_last_row && at_last_col && m_valid;
                if (m_valid && m_ready) begin
                    fifo_pop[cur_row] = 1'b1;
                    if (at_last_col) begin
                        col_nxt = '0;
                        row_nxt = at_last_row ? '0 : cur_row + 1'b1;
                    end else begin
                        col_nxt = cur_col + 1'b1;
                    end
                    if (m_last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                tile_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - directed self-checking bench for systolic_result_collector
module tb_systolic_result_collector;
    import systolic_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_ROWS*D_W_ACC-1:0] in_data;
    logic [N_ROWS-1:0]         in_valid;
    logic [D_W_ACC-1:0]        m_data;
    logic                      m_valid;
    logic                      m_ready;
    logic                      m_last;
    logic [ROW_W-1:0]          m_row;
    logic                      overflow;
    logic                      clr_overflow;
    logic                      tile_done;

    systolic_result_collector #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .m_row        (m_row),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .tile_done    (tile_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [63:0] got_data [$];
    int          got_row  [$];
    bit          got_last [$];
    logic [63:0] exp_q    [$];

    int               cyc = 0;
    int               last_cyc = 0;
    int               done_cnt = 0;
    bit               prev_stall = 0;
    logic [63:0]      prev_data;
    logic [ROW_W-1:0] prev_row;
    logic             prev_last;

    // Inputs change only #1 after posedge, so the negedge view equals what the next edge sees.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_row", m_row, prev_row);
                check("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_row.push_back(int'(m_row));
                got_last.push_back(m_last);
                if (m_last) last_cyc = cyc;
            end
            if (tile_done) begin
                check("tile_done_lat", cyc - last_cyc, 1);
                done_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_row   = m_row;
            prev_last  = m_last;
        end
    end

    task automatic clear_got();
        got_data.delete();
        got_row.delete();
        got_last.delete();
    endtask

    // Row r pushes n beats base+16*r+c starting at cycle st_r (st_r < 0: row idle).
    // While t <= chk_until, m_valid must still be low.
    task automatic push_sched(input int s0, input int s1, input int s2, input int s3,
                              input int n, input logic [63:0] base, input int chk_until);
        int st [4];
        int tmax;
        st = '{s0, s1, s2, s3};
        tmax = 0;
        for (int r = 0; r < 4; r++) if (st[r] >= 0 && st[r] + n > tmax) tmax = st[r] + n;
        for (int t = 0; t < tmax; t++) begin
            if (t <= chk_until) check("no_early_out", m_valid, 0);
            in_valid = '0;
            for (int r = 0; r < 4; r++) begin
                if (st[r] >= 0 && t >= st[r] && t < st[r] + n) begin
                    in_valid[r] = 1'b1;
                    in_data[r*D_W_ACC +: D_W_ACC] = base + 64'(16 * r + (t - st[r]));
                end
            end
            @(posedge clk); #1;
        end
        in_valid = '0;
    endtask

    task automatic wait_done(input int budget, input bit bp);
        int d0;
        bit [3:0] pat;
        d0 = done_cnt;
        pat = 4'b1001;
        for (int k = 0; k < budget; k++) begin
            m_ready = bp ? pat[k % 4] : 1'b1;
            @(posedge clk); #1;
            if (done_cnt != d0) break;
        end
        m_ready = 1'b0;
        check("tile_done_cnt", done_cnt - d0, 1);
    endtask

    task automatic build_exp(input logic [63:0] base);
        exp_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(base + 64'(16 * r + c));
    endtask

    task automatic compare_tile(input string tag);
        check({tag, "_beats"}, got_data.size(), 16);
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            check({tag, "_data"}, got_data[i], exp_q[i]);
            check({tag, "_row"}, got_row[i], i / 4);
            check({tag, "_last"}, got_last[i], (i == 15));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        m_ready = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_row", m_row, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tile_done", tile_done, 0);

        // 1: staggered rows, always ready
        clear_got();
        build_exp(64'h0);
        fork
            push_sched(0, 2, 4, 6, 4, 64'h0, -1);
            wait_done(200, 1'b0);
        join
        compare_tile("t1");

        // 2: rows arrive 3,2,1,0; nothing may leave before row 0 lands
        clear_got();
        build_exp(64'h1000);
        fork
            push_sched(12, 8, 4, 0, 4, 64'h1000, 12);
            wait_done(200, 1'b0);
        join
        compare_tile("t2");

        // 3: m_ready pattern 1,0,0,1 during drain
        clear_got();
        build_exp(64'h2000);
        fork
            push_sched(0, 2, 4, 6, 4, 64'h2000, -1);
            wait_done(300, 1'b1);
        join
        compare_tile("t3");

        // 4: row 1 overflow with 9 beats, then two tiles recover its 8 stored beats
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 4'b0010;
            in_data[1*D_W_ACC +: D_W_ACC] = 64'h100 + 64'(i);
            @(posedge clk); #1;
            if (i == 7) check("t4_ovf_before", overflow, 0);
        end
        in_valid = '0;
        check("t4_ovf_set", overflow, 1);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        clear_got();
        build_exp(64'h700);
        for (int c = 0; c < 4; c++) exp_q[4 + c] = 64'h100 + 64'(c);
        fork
            push_sched(0, -1, 0, 0, 4, 64'h700, -1);
            wait_done(200, 1'b0);
        join
        compare_tile("t4a");
        clear_got();
        build_exp(64'h800);
        for (int c = 0; c < 4; c++) exp_q[4 + c] = 64'h104 + 64'(c);
        fork
            push_sched(0, -1, 0, 0, 4, 64'h800, -1);
            wait_done(200, 1'b0);
        join
        compare_tile("t4b");

        // 5: push into full row 0 while its head handshakes
        push_sched(0, -1, -1, -1, 8, 64'h200, -1);
        check("t5_head", m_data, 64'h200);
        check("t5_valid", m_valid, 1);
        clear_got();
        in_valid = 4'b0001;
        in_data[0 +: D_W_ACC] = 64'h208;
        m_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = '0;
        m_ready = 1'b0;
        check("t5_ovf_stays0", overflow, 0);
        check("t5_next_head", m_data, 64'h201);
        // FIFO must be full again (8 entries), so one more beat is dropped
        in_valid = 4'b0001;
        in_data[0 +: D_W_ACC] = 64'h209;
        @(posedge clk); #1;
        in_valid = '0;
        check("t5_full_count8", overflow, 1);
        build_exp(64'h300);
        for (int c = 0; c < 4; c++) exp_q[c] = 64'h200 + 64'(c);
        fork
            push_sched(-1, 0, 0, 0, 4, 64'h300, -1);
            wait_done(200, 1'b0);
        join
        compare_tile("t5");

        // 6: reset after 5 beats (row 0 holds 0x204..0x208)
        push_sched(-1, 0, -1, -1, 4, 64'h400, -1);
        n = 0;
        for (int k = 0; k < 50 && n < 5; k++) begin
            m_ready = 1'b1;
            @(negedge clk);
            if (m_valid) n++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        check("t6_hs5", n, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_valid", m_valid, 0);
        check("t6_overflow", overflow, 0);
        check("t6_row", m_row, 0);
        check("t6_last", m_last, 0);
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6_empty", m_valid, 0);
        end
        m_ready = 1'b0;
        clear_got();
        build_exp(64'h500);
        fork
            push_sched(0, 2, 4, 6, 4, 64'h500, -1);
            wait_done(200, 1'b0);
        join
        compare_tile("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
